// File: rtl/prism_counter_bank.sv
// prism_counter_bank
// Bank of NCH down-counters sharing one prescaler. The enclosing FSM
// requests per-channel loads and decrements. The block exposes per-channel
// zero flags, sticky hit status and a level interrupt.
//
// Configuration macro: PRISM_CNT_IRQ_EN
//   defined   : IRQ_EN register is read/write and irq = |(STATUS & IRQ_EN)
//   undefined : IRQ_EN reads 0, writes to it are dropped, irq is held at 0
//
// Register map (byte addresses, 32-bit accesses only):
//   0x00      CTRL     [PW-1:0] PDIV, [31] soft clear (write-only, reads 0)
//   0x04      STATUS   [NCH-1:0] sticky hit bits, write-1-to-clear
//   0x08      IRQ_EN   [NCH-1:0]
//   0x10+4i   PRELOAD[i]
//   0x20+4i   COUNT[i] (read-only)

module prism_counter_bank #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int PW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [NCH-1:0]  dec,
    input  logic [NCH-1:0]  load,
    input  logic [5:0]      address,
    input  logic [31:0]     data_in,
    input  logic [1:0]      data_write_n,
    output logic [31:0]     data_out,
    output logic [NCH-1:0]  zero,
    output logic            irq
);

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_STATUS  = 6'h04;
    localparam logic [5:0] ADDR_IRQ_EN  = 6'h08;
    localparam logic [5:0] ADDR_PRELOAD = 6'h10;
    localparam logic [5:0] ADDR_COUNT   = 6'h20;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // State
    logic [PW-1:0]          presc_r;
    logic [PW-1:0]          pdiv_r;
    logic [NCH-1:0][CW-1:0] count_r;
    logic [NCH-1:0][CW-1:0] preload_r;
    logic [NCH-1:0]         status_r;
    logic [NCH-1:0]         irq_en_r;
    logic                   irq_r;

    // Decoded controls
    logic                   wr_en_s;
    logic                   ctrl_wr_s;
    logic                   soft_clr_s;
    logic                   status_wr_s;
    logic                   tick_s;
    logic [NCH-1:0]         preload_wr_s;
    logic [NCH-1:0]         load_s;
    logic [NCH-1:0]         dec_s;
    logic [NCH-1:0]         hit_s;
    logic [NCH-1:0]         status_nxt_s;
    logic [NCH-1:0]         irq_en_nxt_s;
    logic [NCH-1:0]         zero_s;
    logic [31:0]            rd_data_s;
    logic                   unused_data_s;

    assign wr_en_s     = (data_write_n == 2'b10);
    assign ctrl_wr_s   = wr_en_s && (address == ADDR_CTRL);
    assign soft_clr_s  = ctrl_wr_s && data_in[31];
    assign status_wr_s = wr_en_s && (address == ADDR_STATUS);
    assign tick_s      = enable && (presc_r == pdiv_r);

    // Bits 30:PW of data_in have no destination; fold them into a sink.
    assign unused_data_s = ^data_in;

`ifdef PRISM_CNT_IRQ_EN
    logic irq_en_wr_s;
    assign irq_en_wr_s = wr_en_s && (address == ADDR_IRQ_EN);

    // Next IRQ_EN value: software write or hold.
    always_comb begin
        if (irq_en_wr_s) begin
            irq_en_nxt_s = data_in[NCH-1:0];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // IRQ_EN register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_r <= {NCH{1'b0}};
        end else begin
            irq_en_r <= irq_en_nxt_s;
        end
    end
`else
    assign irq_en_nxt_s = {NCH{1'b0}};
    assign irq_en_r     = {NCH{1'b0}};
`endif

    // Per-channel load/decrement qualification, hit detection and PRELOAD decode.
    always_comb begin
        load_s       = {NCH{1'b0}};
        dec_s        = {NCH{1'b0}};
        hit_s        = {NCH{1'b0}};
        preload_wr_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            load_s[i]       = enable && load[i];
            // Load wins over decrement; a zero count never decrements (no wrap).
            dec_s[i]        = tick_s && dec[i] && !load[i] && (count_r[i] != CNT_ZERO);
            hit_s[i]        = dec_s[i] && (count_r[i] == CNT_ONE);
            preload_wr_s[i] = wr_en_s && (address == (ADDR_PRELOAD + 6'(4 * i)));
        end
    end

    // Next STATUS: soft clear, else W1C then sets (a set in the same cycle wins).
    always_comb begin
        if (soft_clr_s) begin
            status_nxt_s = {NCH{1'b0}};
        end else if (status_wr_s) begin
            status_nxt_s = (status_r & ~data_in[NCH-1:0]) | hit_s;
        end else begin
            status_nxt_s = status_r | hit_s;
        end
    end

    // Prescaler: counts enabled cycles and wraps to 0 on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= PRE_ZERO;
        end else if (soft_clr_s) begin
            presc_r <= PRE_ZERO;
        end else if (tick_s) begin
            presc_r <= PRE_ZERO;
        end else if (enable) begin
            // If PDIV is lowered below the running value the prescaler wraps through 2^PW.
            presc_r <= presc_r + PRE_ONE;
        end else begin
            presc_r <= presc_r;
        end
    end

    // PDIV register, written by every committed CTRL write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdiv_r <= PRE_ZERO;
        end else if (ctrl_wr_s) begin
            pdiv_r <= data_in[PW-1:0];
        end else begin
            pdiv_r <= pdiv_r;
        end
    end

    // PRELOAD registers; they only reach the counters through a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preload_r <= {NCH{CNT_ZERO}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (preload_wr_s[i]) begin
                    preload_r[i] <= data_in[CW-1:0];
                end else begin
                    preload_r[i] <= preload_r[i];
                end
            end
        end
    end

    // Counters: soft clear overrides load, load overrides decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {NCH{CNT_ZERO}};
        end else if (soft_clr_s) begin
            count_r <= {NCH{CNT_ZERO}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load_s[i]) begin
                    count_r[i] <= preload_r[i];
                end else if (dec_s[i]) begin
                    count_r[i] <= count_r[i] - CNT_ONE;
                end else begin
                    count_r[i] <= count_r[i];
                end
            end
        end
    end

    // STATUS register and registered interrupt computed from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= {NCH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= status_nxt_s;
            irq_r    <= |(status_nxt_s & irq_en_nxt_s);
        end
    end

    // Zero flags straight from the count registers.
    always_comb begin
        zero_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            zero_s[i] = (count_r[i] == CNT_ZERO);
        end
    end

    // Read mux; unmapped addresses, absent channels and unused bits read 0.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (address)
            ADDR_CTRL:   rd_data_s[PW-1:0]  = pdiv_r;
            ADDR_STATUS: rd_data_s[NCH-1:0] = status_r;
            ADDR_IRQ_EN: rd_data_s[NCH-1:0] = irq_en_r;
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (address == (ADDR_PRELOAD + 6'(4 * i))) begin
                        rd_data_s[CW-1:0] = preload_r[i];
                    end else if (address == (ADDR_COUNT + 6'(4 * i))) begin
                        rd_data_s[CW-1:0] = count_r[i];
                    end else begin
                        // address does not select this channel
                    end
                end
            end
        endcase
    end

    assign data_out = rd_data_s;
    assign zero     = zero_s;
    assign irq      = irq_r;

endmodule

// File: tb/tb_prism_counter_bank.sv
// Directed testbench for prism_counter_bank (NCH=4, CW=16, PW=16).
// Expected irq follows PRISM_CNT_IRQ_EN as seen by this compile.

module tb_prism_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable;
    logic [3:0]  dec;
    logic [3:0]  load;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [31:0] data_out;
    logic [3:0]  zero;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PRISM_CNT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    prism_counter_bank #(.NCH(4), .CW(16), .PW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .dec          (dec),
        .load         (load),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_out     (data_out),
        .zero         (zero),
        .irq          (irq)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time at edge+1.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] ld, input logic [3:0] dc);
        enable = en;
        load   = ld;
        dec    = dc;
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        cyc(1);
        data_write_n = 2'b11;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check_eq(tag, data_out, exp);
    endtask

    task automatic zero_chk(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'h0, zero}, {28'h0, exp});
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        check_eq(tag, {31'h0, irq}, {31'h0, exp});
    endtask

    initial begin
        logic [1:0] bad_wn [3];
        bad_wn[0] = 2'b00;
        bad_wn[1] = 2'b01;
        bad_wn[2] = 2'b11;

        drive(1'b0, 4'h0, 4'h0);
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;

        // Reset behaviour
        #2 rst_n = 1'b0;
        #10;
        zero_chk("in_reset_zero", 4'hF);
        irq_chk("in_reset_irq", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        zero_chk("post_reset_zero", 4'hF);
        irq_chk("post_reset_irq", 1'b0);
        for (int a = 0; a < 64; a++) begin
            rd_chk($sformatf("post_reset_rd_%02h", a), 6'(a), 32'h0);
        end

        // Only 2'b10 commits a write
        for (int k = 0; k < 3; k++) begin
            address      = 6'h10;
            data_in      = 32'h0000_1234;
            data_write_n = bad_wn[k];
            cyc(1);
        end
        data_write_n = 2'b11;
        rd_chk("bad_strobe_ignored", 6'h10, 32'h0);

        // PRELOAD width masking; PRELOAD write does not touch count
        wr_reg(6'h10, 32'hFFFF_FFFF);
        rd_chk("preload0_mask", 6'h10, 32'h0000_FFFF);
        rd_chk("preload_no_count", 6'h20, 32'h0);

        // Channel 0 basic countdown, PDIV=3
        wr_reg(6'h10, 32'd2);
        drive(1'b1, 4'h1, 4'h0);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c0_loaded", 6'h20, 32'd2);
        zero_chk("c0_loaded_zero", 4'hE);
        rd_chk("unaligned_rd", 6'h11, 32'h0);
        rd_chk("unmapped_0c", 6'h0C, 32'h0);
        wr_reg(6'h00, 32'd3);
        rd_chk("ctrl_pdiv3", 6'h00, 32'd3);
        wr_reg(6'h08, 32'h1);
        rd_chk("irq_en_rd", 6'h08, {31'h0, IRQ_ON});
        drive(1'b1, 4'h0, 4'h1);
        cyc(3);
        rd_chk("c0_3cyc", 6'h20, 32'd2);
        cyc(1);
        rd_chk("c0_4cyc", 6'h20, 32'd1);
        cyc(3);
        rd_chk("c0_7cyc", 6'h20, 32'd1);
        zero_chk("c0_7cyc_zero", 4'hE);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c0_8cyc", 6'h20, 32'd0);
        zero_chk("c0_8cyc_zero", 4'hF);
        rd_chk("c0_status", 6'h04, 32'h1);
        irq_chk("c0_irq", IRQ_ON);
        wr_reg(6'h04, 32'h1);
        rd_chk("c0_w1c", 6'h04, 32'h0);
        irq_chk("c0_irq_cleared", 1'b0);

        // Saturation at 0, no new hit
        drive(1'b1, 4'h0, 4'h1);
        cyc(8);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c0_saturate", 6'h20, 32'd0);
        rd_chk("c0_sat_status", 6'h04, 32'h0);

        // COUNT is read-only
        wr_reg(6'h20, 32'h55);
        rd_chk("count_ro", 6'h20, 32'd0);

        // Channel 1: decrement at zero, then load+dec on a tick
        wr_reg(6'h00, 32'd0);
        drive(1'b1, 4'h0, 4'h2);
        cyc(10);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c1_stays0", 6'h24, 32'd0);
        rd_chk("c1_no_status", 6'h04, 32'h0);
        wr_reg(6'h14, 32'd5);
        drive(1'b1, 4'h2, 4'h2);
        cyc(1);
        rd_chk("c1_load_wins", 6'h24, 32'd5);
        drive(1'b1, 4'h0, 4'h2);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c1_dec", 6'h24, 32'd4);

        // Channel 2: W1C colliding with a new hit
        wr_reg(6'h18, 32'd1);
        drive(1'b1, 4'h4, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h4);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c2_hit", 6'h04, 32'h4);
        drive(1'b1, 4'h4, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h4);
        address      = 6'h04;
        data_in      = 32'h4;
        data_write_n = 2'b10;
        cyc(1);
        data_write_n = 2'b11;
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c2_set_wins", 6'h04, 32'h4);
        rd_chk("c2_count0", 6'h28, 32'd0);
        wr_reg(6'h04, 32'h4);
        rd_chk("c2_w1c_alone", 6'h04, 32'h0);

        // Channel 3: load of 0 does not set STATUS
        wr_reg(6'h1C, 32'd3);
        drive(1'b1, 4'h8, 4'h0);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        wr_reg(6'h1C, 32'd0);
        rd_chk("c3_preload_held", 6'h2C, 32'd3);
        drive(1'b1, 4'h8, 4'h0);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c3_load0", 6'h2C, 32'd0);
        rd_chk("c3_load0_status", 6'h04, 32'h0);

        // Hit on channel 1 with only IRQ_EN[0] set -> no irq
        wr_reg(6'h14, 32'd1);
        drive(1'b1, 4'h2, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h2);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("c1_hit_status", 6'h04, 32'h2);
        irq_chk("c1_masked_irq", 1'b0);

        // Soft clear mid-count with prescaler at 7
        wr_reg(6'h00, 32'd20);
        wr_reg(6'h10, 32'd100);
        wr_reg(6'h1C, 32'd200);
        drive(1'b1, 4'h9, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h9);
        cyc(6);
        rd_chk("sc_pre_c0", 6'h20, 32'd100);
        rd_chk("sc_pre_c3", 6'h2C, 32'd200);
        drive(1'b1, 4'h9, 4'h9);
        address      = 6'h00;
        data_in      = 32'h8000_0002;
        data_write_n = 2'b10;
        cyc(1);
        data_write_n = 2'b11;
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("sc_c0", 6'h20, 32'd0);
        rd_chk("sc_c3", 6'h2C, 32'd0);
        rd_chk("sc_status", 6'h04, 32'h0);
        rd_chk("sc_ctrl", 6'h00, 32'd2);
        rd_chk("sc_preload_kept", 6'h10, 32'd100);
        zero_chk("sc_zero", 4'hF);
        // Prescaler restarted at 0: load (0->1), one cycle (1->2), tick next
        drive(1'b1, 4'h1, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h1);
        cyc(1);
        rd_chk("sc_presc_a", 6'h20, 32'd100);
        cyc(1);
        drive(1'b0, 4'h0, 4'h0);
        rd_chk("sc_presc_b", 6'h20, 32'd99);

        // Asynchronous reset mid-count
        wr_reg(6'h00, 32'd0);
        wr_reg(6'h10, 32'd1);
        wr_reg(6'h08, 32'h1);
        drive(1'b1, 4'h1, 4'h0);
        cyc(1);
        drive(1'b1, 4'h0, 4'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        zero_chk("mid_rst_zero", 4'hF);
        irq_chk("mid_rst_irq", 1'b0);
        drive(1'b0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        rd_chk("mid_rst_status", 6'h04, 32'h0);
        rd_chk("mid_rst_preload", 6'h10, 32'h0);
        rd_chk("mid_rst_irq_en", 6'h08, 32'h0);
        irq_chk("mid_rst_irq_after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
